reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 118 +++++++++++
 tb/tb_reg_file_sb.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Dual-write, dual-read register file with a per-register busy scoreboard and a
// sequential bulk-clear engine that walks every entry once.
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra0,
    output logic [XLEN-1:0] rd0,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] rd1,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy0,
    output logic            busy1,
    input  logic            clr_req,
    output logic            clr_busy
);

    typedef enum logic {StIdle, StClear} state_t;

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic            clr_busy_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;

    logic active;
    logic wr0_en;
    logic wr1_en;
    logic iss_en;

    // Register 0 is hard-wired when ZERO_REG is set, so it is filtered out of every update.
    assign active = (state_q == StIdle);
    assign wr0_en = active && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_en = active && we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign iss_en = active && iss_valid && !((ZERO_REG != 0) && (iss_rd == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr_req) begin
                        state_q    <= StClear;
                        clr_busy_q <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                StClear: begin
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_q    <= StIdle;
                        clr_busy_q <= 1'b0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Port 1 is assigned last so it wins a same-address dual write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == StClear) begin
            regs_q[cnt_q] <= '0;
        end else begin
            if (wr0_en) regs_q[wa0] <= wd0;
            if (wr1_en) regs_q[wa1] <= wd1;
        end
    end

    // Issue is applied after the write-clears so a same-cycle issue keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (state_q == StClear) begin
            busy_q[cnt_q] <= 1'b0;
        end else begin
            if (wr0_en) busy_q[wa0] <= 1'b0;
            if (wr1_en) busy_q[wa1] <= 1'b0;
            if (iss_en) busy_q[iss_rd] <= 1'b1;
        end
    end

    always_comb begin
        rd0 = regs_q[ra0];
        if (wr0_en && (wa0 == ra0)) rd0 = wd0;
        if (wr1_en && (wa1 == ra0)) rd0 = wd1;
        if ((ZERO_REG != 0) && (ra0 == '0)) rd0 = '0;

        rd1 = regs_q[ra1];
        if (wr0_en && (wa0 == ra1)) rd1 = wd0;
        if (wr1_en && (wa1 == ra1)) rd1 = wd1;
        if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
    end

    assign busy0    = busy_q[ra0];
    assign busy1    = busy_q[ra1];
    assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: expected values queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            we0, we1, iss_valid, clr_req;
    logic [AW-1:0]   wa0, wa1, ra0, ra1, iss_rd;
    logic [XLEN-1:0] wd0, wd1, rd0, rd1;
    logic            busy0, busy1, clr_busy;

    logic [31:0] model [32];
    logic        bm [32];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra0(ra0), .rd0(rd0), .ra1(ra1), .rd1(rd1),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy0(busy0), .busy1(busy1),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    task automatic drive_idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        iss_valid = 0; iss_rd = '0; clr_req = 0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) begin
            model[i] = '0;
            bm[i] = 1'b0;
        end
    endtask

    // Reference update at an IDLE clock edge; register 0 is hard-wired.
    task automatic model_edge();
        if (we0 && wa0 != 0) begin model[wa0] = wd0; bm[wa0] = 1'b0; end
        if (we1 && wa1 != 0) begin model[wa1] = wd1; bm[wa1] = 1'b0; end
        if (iss_valid && iss_rd != 0) bm[iss_rd] = 1'b1;
    endtask

    function automatic logic [31:0] exp_read(input logic [AW-1:0] ra);
        logic [31:0] v;
        v = model[ra];
        if (we0 && wa0 == ra) v = wd0;
        if (we1 && wa1 == ra) v = wd1;
        if (ra == 0) v = '0;
        return v;
    endfunction

    task automatic fill_regs(input logic [31:0] base);
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            we0 = 1; wa0 = AW'(a); wd0 = base + 32'(a);
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst_n = 0;
        #2;
        for (int i = 0; i < 4; i++) begin
            ra0 = AW'($urandom_range(0, 31));
            ra1 = AW'($urandom_range(0, 31));
            #1;
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_v = exp_q.pop_front(); checks++;
            if (rd0 !== exp_v) begin
                errors++; $display("FAIL reset_rd0: got %h expected %h", rd0, exp_v);
            end
            exp_v = exp_q.pop_front(); checks++;
            if (rd1 !== exp_v) begin
                errors++; $display("FAIL reset_rd1: got %h expected %h", rd1, exp_v);
            end
            exp_v = exp_q.pop_front(); checks++;
            if ({29'b0, clr_busy, busy1, busy0} !== exp_v) begin
                errors++;
                $display("FAIL reset_status: got %b%b%b expected %h", clr_busy, busy1, busy0, exp_v);
            end
        end
        model_zero();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra0 = 5; ra1 = 6;
        #1;
        exp_q.push_back(exp_read(ra0));
        exp_q.push_back(exp_read(ra1));
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL bypass_rd0: got %h expected %h", rd0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin
            errors++; $display("FAIL bypass_rd1_other: got %h expected %h", rd1, exp_v);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive_idle(); ra0 = 5;
        #1;
        exp_q.push_back(32'hDEADBEEF);
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL stored_rd0: got %h expected %h", rd0, exp_v);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra0 = 7; ra1 = 7;
        #1;
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h22);
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin
            errors++; $display("FAIL dual_bypass_rd1: got %h expected %h", rd1, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL dual_bypass_rd0: got %h expected %h", rd0, exp_v);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive_idle();
        #1;
        exp_q.push_back(32'h22);
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin
            errors++; $display("FAIL dual_stored_rd1: got %h expected %h", rd1, exp_v);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we0 = 1; wa0 = 0; wd0 = 32'hFFFF; we1 = 1; wa1 = 0; wd1 = 32'h1234;
        iss_valid = 1; iss_rd = 0; ra0 = 0; ra1 = 0;
        #1;
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL zero_bypass_rd0: got %h expected %h", rd0, exp_v);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive_idle();
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL zero_stored_rd0: got %h expected %h", rd0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, busy0} !== exp_v) begin
            errors++; $display("FAIL zero_busy0: got %b expected %h", busy0, exp_v);
        end
    endtask

    task automatic test_scoreboard();
        // Issue 3; busy must not appear until the edge.
        @(negedge clk);
        iss_valid = 1; iss_rd = 3; ra0 = 3; ra1 = 4;
        #1;
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, busy0} !== exp_v) begin
            errors++; $display("FAIL sb_no_early_busy: got %b expected %h", busy0, exp_v);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive_idle();
        #1;
        exp_q.push_back({31'b0, bm[3]});
        exp_q.push_back({31'b0, bm[4]});
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, busy0} !== exp_v) begin
            errors++; $display("FAIL sb_issue_busy0: got %b expected %h", busy0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, busy1} !== exp_v) begin
            errors++; $display("FAIL sb_other_busy1: got %b expected %h", busy1, exp_v);
        end
        // Write from port 1 clears it.
        we1 = 1; wa1 = 3; wd1 = 32'h33;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive_idle();
        #1;
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, busy0} !== exp_v) begin
            errors++; $display("FAIL sb_write_clears: got %b expected %h", busy0, exp_v);
        end
        // Same-cycle issue and write: issue wins.
        iss_valid = 1; iss_rd = 3; we0 = 1; wa0 = 3; wd0 = 32'h44;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive_idle();
        #1;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h44);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, busy0} !== exp_v) begin
            errors++; $display("FAIL sb_issue_wins: got %b expected %h", busy0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL sb_issue_wins_data: got %h expected %h", rd0, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, 7)); wd1 = $urandom;
            ra0 = AW'($urandom_range(0, 7)); ra1 = AW'($urandom_range(0, 7));
            #1;
            exp_q.push_back(exp_read(ra0));
            exp_q.push_back(exp_read(ra1));
            exp_v = exp_q.pop_front(); checks++;
            if (rd0 !== exp_v) begin
                errors++; $display("FAIL b2b_rd0 cycle %0d: got %h expected %h", c, rd0, exp_v);
            end
            exp_v = exp_q.pop_front(); checks++;
            if (rd1 !== exp_v) begin
                errors++; $display("FAIL b2b_rd1 cycle %0d: got %h expected %h", c, rd1, exp_v);
            end
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_clear();
        int n;
        int busy_list [4] = '{3, 9, 17, 30};
        fill_regs(32'h1000_0000);
        foreach (busy_list[k]) begin
            @(negedge clk);
            iss_valid = 1; iss_rd = AW'(busy_list[k]);
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        drive_idle();
        clr_req = 1;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h1);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, clr_busy} !== exp_v) begin
            errors++; $display("FAIL clear_start: got %b expected %h", clr_busy, exp_v);
        end
        n = 0;
        while (clr_busy === 1'b1 && n < 40) begin
            @(negedge clk);
            clr_req = (n < 5);
            we0 = 1; wa0 = AW'($urandom_range(1, 31)); wd0 = $urandom;
            we1 = 1; wa1 = wa0; wd1 = $urandom;
            iss_valid = 1; iss_rd = wa0;
            ra0 = wa0; ra1 = AW'($urandom_range(1, 31));
            #1;
            exp_q.push_back(model[ra0]);
            exp_q.push_back({31'b0, bm[ra0]});
            exp_v = exp_q.pop_front(); checks++;
            if (rd0 !== exp_v) begin
                errors++; $display("FAIL clear_rd0 cycle %0d: got %h expected %h", n, rd0, exp_v);
            end
            exp_v = exp_q.pop_front(); checks++;
            if ({31'b0, busy0} !== exp_v) begin
                errors++; $display("FAIL clear_busy0 cycle %0d: got %b expected %h", n, busy0, exp_v);
            end
            @(posedge clk);
            if (n < 32) begin
                model[n] = '0;
                bm[n] = 1'b0;
            end
            n++;
            #1;
        end
        @(negedge clk);
        drive_idle();
        exp_q.push_back(32'd32);
        exp_v = exp_q.pop_front(); checks++;
        if (32'(n) !== exp_v) begin
            errors++; $display("FAIL clear_length: got %0d expected %0d", n, exp_v);
        end
        for (int i = 0; i < 32; i++) begin
            ra0 = AW'(i); ra1 = AW'(31 - i);
            #1;
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_v = exp_q.pop_front(); checks++;
            if (rd0 !== exp_v) begin
                errors++; $display("FAIL post_clear_rd0 reg %0d: got %h expected %h", i, rd0, exp_v);
            end
            exp_v = exp_q.pop_front(); checks++;
            if ({30'b0, busy1, busy0} !== exp_v) begin
                errors++;
                $display("FAIL post_clear_busy reg %0d: got %b%b expected %h", i, busy1, busy0, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_regs(32'h2000_0000);
        @(negedge clk);
        clr_req = 1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 0; ra0 = 20; ra1 = 31;
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, clr_busy} !== exp_v) begin
            errors++; $display("FAIL abort_clr_busy: got %b expected %h", clr_busy, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL abort_async_rd0: got %h expected %h", rd0, exp_v);
        end
        model_zero();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 32; i++) begin
            ra0 = AW'(i);
            #1;
            exp_q.push_back(32'h0);
            exp_v = exp_q.pop_front(); checks++;
            if (rd0 !== exp_v) begin
                errors++; $display("FAIL abort_rd0 reg %0d: got %h expected %h", i, rd0, exp_v);
            end
        end
        // Block must be back in IDLE and accepting writes.
        @(negedge clk);
        we0 = 1; wa0 = 4; wd0 = 32'hCAFE0004;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive_idle(); ra0 = 4;
        #1;
        exp_q.push_back(32'hCAFE0004);
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (rd0 !== exp_v) begin
            errors++; $display("FAIL abort_idle_write: got %h expected %h", rd0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, clr_busy} !== exp_v) begin
            errors++; $display("FAIL abort_idle_state: got %b expected %h", clr_busy, exp_v);
        end
    endtask

    initial begin
        ra0 = '0; ra1 = '0;
        drive_idle();
        model_zero();
        test_reset();
        test_bypass();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
